// File: rtl/la_cmd_pkg.sv
// Command-link definitions shared by the logic-analyser command path:
// opcodes, response codes, register/channel maps and command field slices.
package la_cmd_pkg;

    localparam int unsigned BAUD_DIV_DEF     = 868;
    localparam int unsigned TIMEOUT_CLKS_DEF = 17360;

    typedef enum logic [1:0] {
        ReadReg  = 2'b00,
        WriteReg = 2'b01,
        Dump     = 2'b10
    } opcode_e;

    localparam logic [7:0] ACK = 8'hA5;
    localparam logic [7:0] NAK = 8'hEE;

    typedef enum logic [5:0] {
        REG_TRIG_CFG   = 6'h00,
        REG_CH1_TRIG   = 6'h01,
        REG_CH2_TRIG   = 6'h02,
        REG_CH3_TRIG   = 6'h03,
        REG_CH4_TRIG   = 6'h04,
        REG_CH5_TRIG   = 6'h05,
        REG_DEC_PWR    = 6'h06,
        REG_VIH        = 6'h07,
        REG_VIL        = 6'h08,
        REG_MATCH_H    = 6'h09,
        REG_MATCH_L    = 6'h0A,
        REG_MASK_H     = 6'h0B,
        REG_MASK_L     = 6'h0C,
        REG_BAUD_CNT_H = 6'h0D,
        REG_BAUD_CNT_L = 6'h0E,
        REG_TRIG_POS_H = 6'h0F,
        REG_TRIG_POS_L = 6'h10
    } reg_addr_e;

    typedef enum logic [2:0] {
        CH1 = 3'd1,
        CH2 = 3'd2,
        CH3 = 3'd3,
        CH4 = 3'd4,
        CH5 = 3'd5
    } channel_e;

    typedef struct packed {
        logic [1:0] opcode;
        logic [5:0] addr;
        logic [7:0] data;
    } cmd_t;

    function automatic logic [1:0] cmd_opcode(input logic [15:0] c);
        return c[15:14];
    endfunction

    function automatic logic [5:0] cmd_addr(input logic [15:0] c);
        return c[13:8];
    endfunction

    function automatic logic [7:0] cmd_data(input logic [15:0] c);
        return c[7:0];
    endfunction

endpackage

// File: rtl/uart_xcvr.sv
// Bit-level UART receiver and transmitter, 8N1, BAUD_DIV clocks per bit.
// RX and TX share nothing but clock and reset.
module uart_xcvr
    import la_cmd_pkg::*;
#(
    parameter int unsigned BAUD_DIV = BAUD_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic [7:0] rx_byte_o,
    output logic       rx_vld_o,
    output logic       rx_ferr_o,
    output logic       rx_start_o,
    input  logic       trmt_i,
    input  logic [7:0] tx_data_i,
    output logic       tx_o,
    output logic       tx_done_o
);

    localparam logic [9:0] BAUD_LD = 10'(BAUD_DIV - 1);
    localparam logic [9:0] HALF_LD = 10'(BAUD_DIV / 2 - 1);
    localparam logic [3:0] STOP_BIT = 4'd9;

    localparam logic [0:0] RX_IDLE = 1'b0;
    localparam logic [0:0] RX_BUSY = 1'b1;
    localparam logic [0:0] TX_IDLE = 1'b0;
    localparam logic [0:0] TX_BUSY = 1'b1;

    logic [2:0] rx_sync_q;
    logic [0:0] rx_st_q, rx_st_d;
    logic [9:0] rx_baud_q, rx_baud_d;
    logic [3:0] rx_bit_q, rx_bit_d;
    logic [7:0] rx_shft_q, rx_shft_d;
    logic       rx_vld_q, rx_vld_d;
    logic       rx_ferr_q, rx_ferr_d;
    logic       rx_in;
    logic       rx_start;

    logic [0:0] tx_st_q, tx_st_d;
    logic [9:0] tx_baud_q, tx_baud_d;
    logic [3:0] tx_bit_q, tx_bit_d;
    logic [7:0] tx_shft_q, tx_shft_d;
    logic       tx_q, tx_d;
    logic       tx_done_q, tx_done_d;

    // [0],[1] synchronise; [2] is the previous synchronised value for edge detection
    assign rx_in    = rx_sync_q[1];
    assign rx_start = (rx_st_q == RX_IDLE) && rx_sync_q[2] && !rx_sync_q[1];

    always_comb begin
        rx_st_d   = rx_st_q;
        rx_baud_d = rx_baud_q;
        rx_bit_d  = rx_bit_q;
        rx_shft_d = rx_shft_q;
        rx_vld_d  = 1'b0;
        rx_ferr_d = 1'b0;
        if (rx_st_q == RX_IDLE) begin
            if (rx_start) begin
                rx_st_d   = RX_BUSY;
                rx_baud_d = HALF_LD;
                rx_bit_d  = '0;
            end
        end else if (rx_baud_q != '0) begin
            rx_baud_d = rx_baud_q - 10'd1;
        end else begin
            rx_baud_d = BAUD_LD;
            if (rx_bit_q == 4'd0) begin
                if (rx_in) rx_st_d = RX_IDLE;
                else       rx_bit_d = 4'd1;
            end else if (rx_bit_q == STOP_BIT) begin
                rx_st_d   = RX_IDLE;
                rx_vld_d  = rx_in;
                rx_ferr_d = !rx_in;
            end else begin
                rx_shft_d = {rx_in, rx_shft_q[7:1]};
                rx_bit_d  = rx_bit_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync_q <= '1;
            rx_st_q   <= RX_IDLE;
            rx_baud_q <= '0;
            rx_bit_q  <= '0;
            rx_shft_q <= '0;
            rx_vld_q  <= 1'b0;
            rx_ferr_q <= 1'b0;
        end else begin
            rx_sync_q <= {rx_sync_q[1:0], rx_i};
            rx_st_q   <= rx_st_d;
            rx_baud_q <= rx_baud_d;
            rx_bit_q  <= rx_bit_d;
            rx_shft_q <= rx_shft_d;
            rx_vld_q  <= rx_vld_d;
            rx_ferr_q <= rx_ferr_d;
        end
    end

    always_comb begin
        tx_st_d   = tx_st_q;
        tx_baud_d = tx_baud_q;
        tx_bit_d  = tx_bit_q;
        tx_shft_d = tx_shft_q;
        tx_d      = tx_q;
        tx_done_d = 1'b0;
        if (tx_st_q == TX_IDLE) begin
            if (trmt_i) begin
                tx_st_d   = TX_BUSY;
                tx_shft_d = tx_data_i;
                tx_d      = 1'b0;
                tx_baud_d = BAUD_LD;
                tx_bit_d  = '0;
            end
        end else if (tx_baud_q != '0) begin
            tx_baud_d = tx_baud_q - 10'd1;
        end else if (tx_bit_q == STOP_BIT) begin
            tx_st_d   = TX_IDLE;
            tx_d      = 1'b1;
            tx_done_d = 1'b1;
        end else begin
            // bit_q names the bit just finished; drive the one that follows it
            tx_baud_d = BAUD_LD;
            tx_bit_d  = tx_bit_q + 4'd1;
            if (tx_bit_q == 4'd8) begin
                tx_d = 1'b1;
            end else begin
                tx_d      = tx_shft_q[0];
                tx_shft_d = {1'b0, tx_shft_q[7:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_st_q   <= TX_IDLE;
            tx_baud_q <= '0;
            tx_bit_q  <= '0;
            tx_shft_q <= '0;
            tx_q      <= 1'b1;
            tx_done_q <= 1'b0;
        end else begin
            tx_st_q   <= tx_st_d;
            tx_baud_q <= tx_baud_d;
            tx_bit_q  <= tx_bit_d;
            tx_shft_q <= tx_shft_d;
            tx_q      <= tx_d;
            tx_done_q <= tx_done_d;
        end
    end

    assign rx_byte_o  = rx_shft_q;
    assign rx_vld_o   = rx_vld_q;
    assign rx_ferr_o  = rx_ferr_q;
    assign rx_start_o = rx_start;
    assign tx_o       = tx_q;
    assign tx_done_o  = tx_done_q;

endmodule

// File: rtl/cmd_uart_slave.sv
// Host command link, DUT side: assembles 16-bit commands from two UART bytes and sends responses.
// Optional inter-byte timeout enabled by defining CMD_TIMEOUT_EN.
module cmd_uart_slave
    import la_cmd_pkg::*;
#(
    parameter int unsigned BAUD_DIV     = BAUD_DIV_DEF,
    parameter int unsigned TIMEOUT_CLKS = TIMEOUT_CLKS_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        resp_sent
);

    localparam logic [0:0] ST_HIGH = 1'b0;
    localparam logic [0:0] ST_LOW  = 1'b1;

    logic [7:0]  rx_byte;
    logic        rx_vld;
    logic        rx_ferr;
    logic        rx_start;

    logic [0:0]  byte_st_q, byte_st_d;
    logic [7:0]  high_q, high_d;
    logic [15:0] cmd_q, cmd_d;
    logic        cmd_rdy_q, cmd_rdy_d;

    uart_xcvr #(
        .BAUD_DIV (BAUD_DIV)
    ) u_xcvr (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_i       (RX),
        .rx_byte_o  (rx_byte),
        .rx_vld_o   (rx_vld),
        .rx_ferr_o  (rx_ferr),
        .rx_start_o (rx_start),
        .trmt_i     (send_resp),
        .tx_data_i  (resp),
        .tx_o       (TX),
        .tx_done_o  (resp_sent)
    );

`ifdef CMD_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CLKS - 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            timeout;

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (byte_st_q == ST_HIGH || rx_start) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != TO_LAST) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    assign timeout = (byte_st_q == ST_LOW) && (to_cnt_q == TO_LAST) && !rx_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) to_cnt_q <= '0;
        else        to_cnt_q <= to_cnt_d;
    end
`else
    logic timeout;
    assign timeout = 1'b0;
`endif

    always_comb begin
        byte_st_d = byte_st_q;
        high_d    = high_q;
        cmd_d     = cmd_q;
        cmd_rdy_d = cmd_rdy_q;
        if (clr_cmd_rdy || (rx_start && byte_st_q == ST_HIGH)) begin
            cmd_rdy_d = 1'b0;
        end
        // A completing command overrides the clear above: set wins
        if (rx_ferr) begin
            byte_st_d = ST_HIGH;
        end else if (rx_vld) begin
            if (byte_st_q == ST_HIGH) begin
                high_d    = rx_byte;
                byte_st_d = ST_LOW;
            end else begin
                cmd_d     = {high_q, rx_byte};
                cmd_rdy_d = 1'b1;
                byte_st_d = ST_HIGH;
            end
        end else if (timeout) begin
            byte_st_d = ST_HIGH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_st_q <= ST_HIGH;
            high_q    <= '0;
            cmd_q     <= '0;
            cmd_rdy_q <= 1'b0;
        end else begin
            byte_st_q <= byte_st_d;
            high_q    <= high_d;
            cmd_q     <= cmd_d;
            cmd_rdy_q <= cmd_rdy_d;
        end
    end

    assign cmd     = cmd_q;
    assign cmd_rdy = cmd_rdy_q;

endmodule

// File: tb/tb_cmd_uart_slave.sv
// Directed self-checking bench for cmd_uart_slave; expected cmd after the idle gap depends on CMD_TIMEOUT_EN.
module tb_cmd_uart_slave;

    localparam int unsigned B    = 217;
    localparam int unsigned HB   = B / 2;
    localparam int unsigned TOUT = 20 * B;

    logic        clk         = 1'b0;
    logic        rst_n       = 1'b0;
    logic        RX          = 1'b1;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic [7:0]  resp        = 8'h00;
    logic        send_resp   = 1'b0;
    logic        resp_sent;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [9:0]  fr;
    int unsigned len;
    logic        lo_end;
    logic        hi_start;

    cmd_uart_slave #(
        .BAUD_DIV     (B),
        .TIMEOUT_CLKS (TOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RX          (RX),
        .TX          (TX),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp        (resp),
        .send_resp   (send_resp),
        .resp_sent   (resp_sent)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; leaves RX idle-high for a few clocks afterwards.
    task automatic send_byte(input logic [7:0] b, input logic stop, input logic clr_same);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            RX = frame[k];
            for (int c = 0; c < int'(B); c++) begin
                if (clr_same && k == 9 && c == int'(HB) + 3) clr_cmd_rdy = 1'b1;
                if (clr_same && k == 9 && c == int'(HB) + 4) clr_cmd_rdy = 1'b0;
                @(negedge clk);
            end
        end
        RX = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Caller raised send_resp at a negedge; captures the frame mid-bit and counts clocks to resp_sent.
    task automatic tx_frame(output logic [9:0] f, output int unsigned n_out,
                            output logic start_last, output logic bit0_first,
                            input logic inject, input logic chain);
        int unsigned n;
        n = 0;
        f = '1;
        start_last = 1'bx;
        bit0_first = 1'bx;
        @(negedge clk);
        send_resp = 1'b0;
        while (resp_sent !== 1'b1 && n < 12 * B) begin
            if ((n % B) == HB && (n / B) < 10) f[n / B] = TX;
            if (n == B - 1) start_last = TX;
            if (n == B) bit0_first = TX;
            if (inject && n == 3 * B) begin
                resp      = 8'h11;
                send_resp = 1'b1;
            end
            if (inject && n == 3 * B + 1) send_resp = 1'b0;
            @(negedge clk);
            n++;
        end
        n_out = n;
        if (chain) send_resp = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_tx", TX, 1'b1);
        check("reset_cmd", cmd, 16'h0000);
        check("reset_cmd_rdy", cmd_rdy, 1'b0);
        check("reset_resp_sent", resp_sent, 1'b0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Response A5: start bit exactly B clocks, LSB first, resp_sent at 10*B
        resp      = 8'hA5;
        send_resp = 1'b1;
        tx_frame(fr, len, lo_end, hi_start, 1'b0, 1'b0);
        check("tx_a5_frame", fr, {1'b1, 8'hA5, 1'b0});
        check("tx_start_last_clk", lo_end, 1'b0);
        check("tx_bit0_first_clk", hi_start, 1'b1);
        check("tx_a5_len", len, 10 * B);
        @(negedge clk);
        check("tx_idle_after", TX, 1'b1);
        check("resp_sent_pulse", resp_sent, 1'b0);

        // Reset mid-frame forces TX high at once
        resp      = 8'h00;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        repeat (3 * B) @(negedge clk);
        check("tx_midframe_low", TX, 1'b0);
        rst_n = 1'b0;
        #1;
        check("tx_reset_abort", TX, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Command 4780
        send_byte(8'h47, 1'b1, 1'b0);
        check("rdy_after_high", cmd_rdy, 1'b0);
        send_byte(8'h80, 1'b1, 1'b0);
        check("cmd_4780", cmd, 16'h4780);
        check("rdy_4780", cmd_rdy, 1'b1);
        repeat (10) @(negedge clk);
        check("rdy_held", cmd_rdy, 1'b1);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        check("rdy_cleared", cmd_rdy, 1'b0);

        // Start-bit glitch: no byte, alignment intact
        RX = 1'b0;
        repeat (20) @(negedge clk);
        RX = 1'b1;
        repeat (B) @(negedge clk);
        check("glitch_cmd", cmd, 16'h4780);

        // Framing error on the second byte, then a clean pair
        send_byte(8'h55, 1'b1, 1'b0);
        send_byte(8'hAA, 1'b0, 1'b0);
        check("ferr_rdy", cmd_rdy, 1'b0);
        check("ferr_cmd", cmd, 16'h4780);
        send_byte(8'h00, 1'b1, 1'b0);
        send_byte(8'h0F, 1'b1, 1'b0);
        check("cmd_000f", cmd, 16'h000F);
        check("rdy_000f", cmd_rdy, 1'b1);

        // New high byte start clears cmd_rdy; clear coinciding with completion loses to set
        send_byte(8'h9C, 1'b1, 1'b0);
        check("rdy_new_start", cmd_rdy, 1'b0);
        send_byte(8'h3E, 1'b1, 1'b1);
        check("rdy_set_wins", cmd_rdy, 1'b1);
        check("cmd_9c3e", cmd, 16'h9C3E);

        // EE with 11 requested mid-frame (ignored), then 11 issued with resp_sent
        resp      = 8'hEE;
        send_resp = 1'b1;
        tx_frame(fr, len, lo_end, hi_start, 1'b1, 1'b1);
        check("tx_ee_frame", fr, {1'b1, 8'hEE, 1'b0});
        check("tx_ee_len", len, 10 * B);
        tx_frame(fr, len, lo_end, hi_start, 1'b0, 1'b0);
        check("tx_11_frame", fr, {1'b1, 8'h11, 1'b0});
        check("tx_11_len", len, 10 * B);

        // Long idle between high and low byte
        send_byte(8'h12, 1'b1, 1'b0);
        check("rdy_cleared_by_12", cmd_rdy, 1'b0);
        repeat (TOUT) @(negedge clk);
        send_byte(8'h34, 1'b1, 1'b0);
`ifdef CMD_TIMEOUT_EN
        check("to_rdy_after_34", cmd_rdy, 1'b0);
        send_byte(8'h56, 1'b1, 1'b0);
        check("to_cmd_3456", cmd, 16'h3456);
        check("to_rdy_3456", cmd_rdy, 1'b1);
`else
        check("noto_cmd_1234", cmd, 16'h1234);
        check("noto_rdy_1234", cmd_rdy, 1'b1);
        send_byte(8'h56, 1'b1, 1'b0);
        check("noto_cmd_held", cmd, 16'h1234);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
